instruction_fetch: RTL

//  Fetch stage of the 5-stage MIPS pipeline. Holds the PC and a debug-loadable

---
 rtl/instruction_fetch.sv | 90 +++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage of the 5-stage MIPS pipeline. It holds the PC and a
// debug-writable instruction memory, and it picks the next PC from the
// sequential, branch, J and JR sources. It drives the IF/ID register
// ({instruction, PC+4}) and supports stall, flush, sticky HALT detection
// and debug-unit freezing.
module instruction_fetch #(
    parameter int unsigned NB_REG    = 32,
    parameter int unsigned NB_IMEM   = 8,
    parameter logic [NB_REG-1:0] HALT_INST = 32'hFFFFFFFF
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_dunit_clk_en,
    input  logic                i_stall,
    input  logic                i_flush,
    input  logic                i_PCSrc,
    input  logic [NB_REG-1:0]   i_branch_target,
    input  logic                i_jr,
    input  logic [NB_REG-1:0]   i_pc_jsel,
    input  logic                i_j,
    input  logic [25:0]         i_j_index,
    input  logic                i_inst_wr_en,
    input  logic [NB_IMEM-1:0]  i_inst_wr_addr,
    input  logic [NB_REG-1:0]   i_inst_wr_data,
    output logic [NB_REG-1:0]   o_inst,
    output logic [NB_REG-1:0]   o_pcplus4,
    output logic [NB_REG-1:0]   o_pc,
    output logic                o_halt
);

    logic [NB_REG-1:0] mem [2**NB_IMEM];
    logic [NB_REG-1:0] fetched;
    logic [NB_REG-1:0] pc_plus4;
    logic [NB_REG-1:0] next_pc;

    // Debug-unit writes to memory. They are not gated by the freeze
    // control, and memory has no reset.
    always_ff @(posedge i_clk) begin
        if (i_inst_wr_en) begin
            mem[i_inst_wr_addr] <= i_inst_wr_data;
        end
    end

    // Combinational word read. PC[1:0] are ignored, and the upper PC bits
    // alias onto the same words.
    always_comb begin
        fetched  = mem[o_pc[NB_IMEM+1:2]];
        pc_plus4 = o_pc + NB_REG'(4);
    end

    // Next-PC selection. JR has the highest priority, then J, then the
    // taken branch.
    always_comb begin
        next_pc = pc_plus4;
        if (i_jr) begin
            next_pc = i_pc_jsel;
        end else if (i_j) begin
            next_pc = {o_pc[NB_REG-1:28], i_j_index, 2'b00};
        end else if (i_PCSrc) begin
            next_pc = i_branch_target;
        end
    end

    // Updates the PC, the IF/ID register and the sticky halt flag. A
    // redirect never flushes, so the delay-slot word still enters IF/ID.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            o_pc      <= '0;
            o_inst    <= '0;
            o_pcplus4 <= '0;
            o_halt    <= 1'b0;
        end else if (i_dunit_clk_en) begin
            if (o_halt) begin
                o_inst    <= '0;
                o_pcplus4 <= pc_plus4;
            end else if (!i_stall) begin
                if (fetched == HALT_INST) begin
                    o_inst    <= HALT_INST;
                    o_pcplus4 <= pc_plus4;
                    o_halt    <= 1'b1;
                end else begin
                    o_inst    <= i_flush ? '0 : fetched;
                    o_pcplus4 <= pc_plus4;
                    o_pc      <= next_pc;
                end
            end
        end
    end

endmodule
